// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared constants and types for the RAM-backed FIFO controller.
//   DW_DEF / DEPTH_DEF : default data width and entry count (match the 4x4 RAM).
//   ram_op_e           : encoding of the RAM SEL pin (0 = read, 1 = write).
//   ptr_t              : pointer type for the default depth.
package ram_fifo_pkg;
   localparam int DW_DEF    = 4;
   localparam int DEPTH_DEF = 4;
   localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

   typedef enum logic {
      RAM_RD = 1'b0,
      RAM_WR = 1'b1
   } ram_op_e;

   typedef logic [PTR_W_DEF-1:0] ptr_t;
endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: write/read pointers and occupancy counter for the RAM FIFO.
//   clk, reset        : clock, async active-high reset
//   inc_wr_i/inc_rd_i : advance write / read pointer (never both in one cycle)
//   wr_ptr_o/rd_ptr_o : current RAM addresses for next write / read
//   count_o           : occupancy 0..DEPTH
//   full_o/empty_o    : decoded from count
module fifo_ptr_cnt #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc_wr_i,
   input  logic          inc_rd_i,
   output logic [AW-1:0] wr_ptr_o,
   output logic [AW-1:0] rd_ptr_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (inc_wr_i) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         count_d  = count_q + (AW+1)'(1);
      end else if (inc_rd_i) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;
   assign full_o   = (count_q == (AW+1)'(DEPTH));
   assign empty_o  = (count_q == '0);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns the external single-port 4x4 RAM (registered Dout)
// into a FIFO with push/pop handshakes.
//   push_valid/push_data/push_ready : producer side
//   pop_valid/pop_ready             : consumer request side
//   rd_valid/rd_data                : returned word, one cycle after pop accept
//   count/full/empty                : occupancy status
//   ram_sel/ram_addr/ram_din        : RAM drive; ram_dout is RAM read data
//   err_ovf/err_udf                 : sticky misuse flags, live only when
//                                     RAM_FIFO_ERR_EN is defined, else tied 0
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter  int DW    = DW_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_valid,
   input  logic [DW-1:0] push_data,
   output logic          push_ready,
   input  logic          pop_valid,
   output logic          pop_ready,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ram_sel,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          err_ovf,
   output logic          err_udf
);
   logic          push_go, pop_go;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          rd_valid_q, rd_valid_d;
   ram_op_e       ram_op;

   // One RAM port: a pending pop wins over a push unless there is nothing
   // to pop, so the two grants are mutually exclusive.
   assign pop_ready  = !empty;
   assign push_ready = !full && !(pop_valid && !empty);
   assign pop_go     = pop_valid && pop_ready;
   assign push_go    = push_valid && push_ready;

   fifo_ptr_cnt #(.DEPTH(DEPTH)) u_ptr (
      .clk      (clk),
      .reset    (reset),
      .inc_wr_i (push_go),
      .inc_rd_i (pop_go),
      .wr_ptr_o (wr_ptr),
      .rd_ptr_o (rd_ptr),
      .count_o  (count),
      .full_o   (full),
      .empty_o  (empty)
   );

   // Idle cycles issue a harmless read of the head entry.
   always_comb begin
      ram_op   = RAM_RD;
      ram_addr = rd_ptr;
      if (push_go) begin
         ram_op   = RAM_WR;
         ram_addr = wr_ptr;
      end
   end

   assign ram_sel = ram_op;
   assign ram_din = push_data;

   // RAM registers Dout on the accepting edge, so a registered valid lines
   // up with the combinational pass-through of ram_dout.
   assign rd_valid_d = pop_go;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_valid_q <= 1'b0;
      else       rd_valid_q <= rd_valid_d;
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = ram_dout;

`ifdef RAM_FIFO_ERR_EN
   logic err_ovf_q, err_udf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         if (push_valid && full)  err_ovf_q <= 1'b1;
         if (pop_valid  && empty) err_udf_q <= 1'b1;
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl with a behavioural
// 4x4 RAM (registered Dout) and a data scoreboard on the read-return port.
module tb_ram_fifo_ctrl;
   localparam int DW = 4, DEPTH = 4, AW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          push_valid, pop_valid;
   logic [DW-1:0] push_data;
   logic          push_ready, pop_ready, rd_valid, full, empty, ram_sel;
   logic [DW-1:0] rd_data, ram_din, ram_dout;
   logic [AW:0]   count;
   logic [AW-1:0] ram_addr;
   logic          err_ovf, err_udf;

   ram_fifo_ctrl dut (
      .clk(clk), .reset(reset),
      .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
      .pop_valid(pop_valid), .pop_ready(pop_ready),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty),
      .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .err_ovf(err_ovf), .err_udf(err_udf)
   );

   always #5 clk = ~clk;

   // External RAM model: SEL=1 writes, SEL=0 reads into a registered Dout.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] dout_q = '0;
   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_sel) mem[ram_addr] <= ram_din;
      else         dout_q <= mem[ram_addr];
   end
   assign ram_dout = dout_q;

   int n_chk = 0, n_pass = 0;

   // Reference state, advanced by tick() from the driven stimulus.
   logic [DW-1:0] exp_q[$];
   int   m_cnt = 0;
   logic m_ovf = 1'b0, m_udf = 1'b0, m_rv = 1'b0;

   // Scoreboard: every rd_valid pulse must carry the oldest pushed word.
   always @(negedge clk) begin
      if (!reset && rd_valid) begin
         n_chk++;
         if (exp_q.size() == 0)
            $display("FAIL sb_unexpected: rd_valid with rd_data=%h, none expected", rd_data);
         else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) $display("FAIL sb_data: got %h expected %h", rd_data, e);
            else n_pass++;
         end
      end
   end

   task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic ppv);
      push_valid = pv; push_data = pd; pop_valid = ppv;
      #1;
   endtask

   task automatic tick();
      logic pg, wg;
      pg = pop_valid && (m_cnt != 0);
      wg = push_valid && (m_cnt != DEPTH) && !pg;
`ifdef RAM_FIFO_ERR_EN
      if (push_valid && m_cnt == DEPTH) m_ovf = 1'b1;
      if (pop_valid && m_cnt == 0)      m_udf = 1'b1;
`endif
      if (wg) begin exp_q.push_back(push_data); m_cnt++; end
      if (pg) m_cnt--;
      m_rv = pg;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0);
      reset = 1'b1;
      exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0);
      @(posedge clk); #1;
      n_chk++; if (count !== 3'd0) $display("FAIL rst_count: got %0d expected 0", count); else n_pass++;
      n_chk++; if ({empty, full, rd_valid} !== 3'b100)
         $display("FAIL rst_flags: empty/full/rd_valid got %b expected 100", {empty, full, rd_valid}); else n_pass++;
      n_chk++; if ({err_ovf, err_udf} !== 2'b00)
         $display("FAIL rst_err: got %b expected 00", {err_ovf, err_udf}); else n_pass++;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_fill();
      logic [DW-1:0] vals [4] = '{4'h3, 4'h5, 4'h9, 4'hC};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[i], 1'b0);
         n_chk++; if ({push_ready, ram_sel, ram_addr, ram_din} !== {2'b11, 2'(i), vals[i]})
            $display("FAIL fill_drive%0d: rdy/sel/addr/din got %b/%b/%0d/%h expected 1/1/%0d/%h",
                     i, push_ready, ram_sel, ram_addr, ram_din, i, vals[i]); else n_pass++;
         tick();
         n_chk++; if (count !== 3'(i + 1)) $display("FAIL fill_count%0d: got %0d expected %0d", i, count, i + 1); else n_pass++;
      end
      n_chk++; if ({full, empty} !== 2'b10) $display("FAIL fill_full: full/empty got %b expected 10", {full, empty}); else n_pass++;
      // Fifth push is only offered, then withdrawn before the edge.
      drive(1'b1, 4'hF, 1'b0);
      n_chk++; if ({push_ready, ram_sel} !== 2'b00)
         $display("FAIL fill_5th: push_ready/ram_sel got %b expected 00", {push_ready, ram_sel}); else n_pass++;
      drive(1'b0, '0, 1'b0);
   endtask

   task automatic test_drain(input int n, input int addr0);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, 1'b1);
         n_chk++; if ({pop_ready, ram_sel, ram_addr} !== {2'b10, 2'((addr0 + i) % DEPTH)})
            $display("FAIL drain_drive%0d: rdy/sel/addr got %b/%b/%0d expected 1/0/%0d",
                     i, pop_ready, ram_sel, ram_addr, (addr0 + i) % DEPTH); else n_pass++;
         tick();
         n_chk++; if ({rd_valid, count} !== {1'b1, 3'(m_cnt)})
            $display("FAIL drain_post%0d: rd_valid/count got %b/%0d expected 1/%0d", i, rd_valid, count, m_cnt); else n_pass++;
      end
      drive(1'b0, '0, 1'b0);
      tick();
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL drain_rv_end: got %b expected 0", rd_valid); else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 4'(i + 1), 1'b0); tick(); end
      test_drain(3, 0);
      drive(1'b1, 4'hA, 1'b0);
      n_chk++; if ({ram_sel, ram_addr} !== 3'b111) $display("FAIL wrap_A: sel/addr got %b/%0d expected 1/3", ram_sel, ram_addr); else n_pass++;
      tick();
      drive(1'b1, 4'hB, 1'b0);
      n_chk++; if ({ram_sel, ram_addr} !== 3'b100) $display("FAIL wrap_B: sel/addr got %b/%0d expected 1/0", ram_sel, ram_addr); else n_pass++;
      tick();
      test_drain(2, 3);
      n_chk++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b expected 1", empty); else n_pass++;
   endtask

   task automatic test_contention();
      drive(1'b1, 4'h8, 1'b0); tick();
      drive(1'b1, 4'h2, 1'b0); tick();
      drive(1'b1, 4'h7, 1'b1);
      n_chk++; if ({push_ready, pop_ready, ram_sel} !== 3'b010)
         $display("FAIL cont_pop_wins: push_rdy/pop_rdy/sel got %b expected 010", {push_ready, pop_ready, ram_sel}); else n_pass++;
      tick();
      n_chk++; if (count !== 3'd1) $display("FAIL cont_cnt1: got %0d expected 1", count); else n_pass++;
      drive(1'b1, 4'h7, 1'b0);
      n_chk++; if (push_ready !== 1'b1) $display("FAIL cont_push_next: got %b expected 1", push_ready); else n_pass++;
      tick();
      n_chk++; if (count !== 3'd2) $display("FAIL cont_cnt2: got %0d expected 2", count); else n_pass++;
      test_drain(2, 2);
      drive(1'b1, 4'h6, 1'b1);
      n_chk++; if ({push_ready, pop_ready, ram_sel} !== 3'b101)
         $display("FAIL cont_empty: push_rdy/pop_rdy/sel got %b expected 101", {push_ready, pop_ready, ram_sel}); else n_pass++;
      tick();
      n_chk++; if ({count, rd_valid} !== {3'd1, 1'b0})
         $display("FAIL cont_empty_post: count/rd_valid got %0d/%b expected 1/0", count, rd_valid); else n_pass++;
      n_chk++; if (err_udf !== m_udf) $display("FAIL cont_udf: got %b expected %b", err_udf, m_udf); else n_pass++;
      test_drain(1, 0);
   endtask

   task automatic test_reset_mid_pop();
      drive(1'b1, 4'h4, 1'b0); tick();
      drive(1'b1, 4'hD, 1'b0); tick();
      drive(1'b0, '0, 1'b1);
      n_chk++; if (pop_ready !== 1'b1) $display("FAIL mid_pop_rdy: got %b expected 1", pop_ready); else n_pass++;
      reset = 1'b1;
      exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
      #1;
      n_chk++; if ({rd_valid, count, empty} !== {1'b0, 3'd0, 1'b1})
         $display("FAIL mid_rst: rd_valid/count/empty got %b/%0d/%b expected 0/0/1", rd_valid, count, empty); else n_pass++;
      pop_valid = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL mid_rst_rv: got %b expected 0", rd_valid); else n_pass++;
      reset = 1'b0;
      drive(1'b1, 4'hE, 1'b0);
      n_chk++; if ({ram_sel, ram_addr} !== 3'b100) $display("FAIL mid_push: sel/addr got %b/%0d expected 1/0", ram_sel, ram_addr); else n_pass++;
      tick();
      test_drain(1, 0);
   endtask

   task automatic test_err();
      do_reset();
      drive(1'b0, '0, 1'b1); tick();
      n_chk++; if ({err_udf, count} !== {m_udf, 3'd0})
         $display("FAIL err_udf: err_udf/count got %b/%0d expected %b/0", err_udf, count, m_udf); else n_pass++;
      for (int i = 0; i < 4; i++) begin drive(1'b1, 4'(i + 8), 1'b0); tick(); end
      drive(1'b1, 4'hF, 1'b0); tick();
      n_chk++; if ({err_ovf, count} !== {m_ovf, 3'd4})
         $display("FAIL err_ovf: err_ovf/count got %b/%0d expected %b/4", err_ovf, count, m_ovf); else n_pass++;
      test_drain(4, 0);
      n_chk++; if ({err_ovf, err_udf} !== {m_ovf, m_udf})
         $display("FAIL err_sticky: got %b expected %b", {err_ovf, err_udf}, {m_ovf, m_udf}); else n_pass++;
      do_reset();
      n_chk++; if ({err_ovf, err_udf} !== 2'b00) $display("FAIL err_clear: got %b expected 00", {err_ovf, err_udf}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain(4, 0);
      n_chk++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else n_pass++;
      test_wrap();
      test_contention();
      test_reset_mid_pop();
      test_err();
      n_chk++; if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d words never returned, expected 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
